// File: rtl/opamp_trim_ctrl.sv
// rtl/opamp_trim_ctrl.sv - SAR offset-trim calibration controller for the on-die opamp (option: CAL_AVG_EN)
module opamp_trim_ctrl #(
    parameter int TRIM_W     = 6,
    parameter int SETTLE_CYC = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              start,
    input  logic              abort,
    input  logic              cmp_in,
    input  logic              man_load,
    input  logic [TRIM_W-1:0] man_trim,
    output logic [TRIM_W-1:0] trim,
    output logic              cal_en,
    output logic              busy,
    output logic              done,
    output logic              cal_ok
);

    localparam int BIT_W = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;
    localparam int CNT_W = $clog2(SETTLE_CYC);
    localparam logic [TRIM_W-1:0] MID        = {1'b1, {(TRIM_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [BIT_W-1:0]  BIT_TOP    = BIT_W'(TRIM_W - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    state_t            state;
    logic [TRIM_W-1:0] saved;
    logic [BIT_W-1:0]  bit_idx;
    logic [CNT_W-1:0]  cnt;
    logic              sync1;
    logic              cmp_s;
    logic              decision;
    logic [TRIM_W-1:0] decided;
    logic [TRIM_W-1:0] trial;
    logic              cal_stop;

`ifdef CAL_AVG_EN
    logic [1:0]        samp_cnt;
    logic              vote0;
    logic              vote1;
`endif

    // Two-flop synchronizer for the asynchronous comparator output
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            cmp_s <= 1'b0;
        end else begin
            sync1 <= cmp_in;
            cmp_s <= sync1;
        end
    end

    // Bit decision for the current trial and the next trial code
    always_comb begin
        decided  = trim;
        trial    = trim;
`ifdef CAL_AVG_EN
        decision = (vote0 & vote1) | (vote0 & cmp_s) | (vote1 & cmp_s);
`else
        decision = cmp_s;
`endif
        if (decision) begin
            decided[bit_idx] = 1'b0;
        end
        trial = decided;
        if (bit_idx != '0) begin
            trial[bit_idx - 1'b1] = 1'b1;
        end
    end

    // Abort or disable during the search drops back to IDLE with the old code
    assign cal_stop = ((state == SETTLE) || (state == SAMPLE)) && (abort || !ena);

    // Calibration sequencer with registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            trim    <= MID;
            saved   <= MID;
            bit_idx <= '0;
            cnt     <= '0;
            cal_en  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cal_ok  <= 1'b0;
`ifdef CAL_AVG_EN
            samp_cnt <= 2'd0;
            vote0    <= 1'b0;
            vote1    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (cal_stop) begin
                state  <= IDLE;
                trim   <= saved;
                cal_en <= 1'b0;
                busy   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (ena && start) begin
                            saved   <= trim;
                            trim    <= MID;
                            bit_idx <= BIT_TOP;
                            cnt     <= CNT_RELOAD;
                            cal_en  <= 1'b1;
                            busy    <= 1'b1;
                            cal_ok  <= 1'b0;
                            state   <= SETTLE;
                        end else if (ena && man_load) begin
                            trim <= man_trim;
                        end
                    end
                    SETTLE: begin
                        if (cnt == '0) begin
                            state <= SAMPLE;
`ifdef CAL_AVG_EN
                            samp_cnt <= 2'd0;
`endif
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    SAMPLE: begin
`ifdef CAL_AVG_EN
                        if (samp_cnt != 2'd2) begin
                            if (samp_cnt == 2'd0) begin
                                vote0 <= cmp_s;
                            end else begin
                                vote1 <= cmp_s;
                            end
                            samp_cnt <= samp_cnt + 2'd1;
                        end else
`endif
                        if (bit_idx == '0) begin
                            trim  <= decided;
                            state <= DONE;
                        end else begin
                            trim    <= trial;
                            bit_idx <= bit_idx - 1'b1;
                            cnt     <= CNT_RELOAD;
                            state   <= SETTLE;
                        end
                    end
                    DONE: begin
                        done   <= 1'b1;
                        cal_ok <= 1'b1;
                        cal_en <= 1'b0;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_opamp_trim_ctrl.sv
// tb/tb_opamp_trim_ctrl.sv - directed table-driven bench for opamp_trim_ctrl
module tb_opamp_trim_ctrl;

    localparam int TW = 6;
    localparam int SC = 4;
`ifdef CAL_AVG_EN
    localparam int PER = SC + 3;
    localparam int NV  = 6;
`else
    localparam int PER = SC + 1;
    localparam int NV  = 5;
`endif
    localparam int LAT = 1 + TW * PER;

    logic          clk = 1'b0;
    logic          rst_n, ena, start, abort, man_load;
    logic [TW-1:0] man_trim;
    logic [TW-1:0] trim;
    logic          cal_en, busy, done, cal_ok;
    logic          cmp_in;
    int            model;
    logic          glitch;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Comparator model: 0 -> trim>37, 1 -> constant 0, 2 -> constant 1
    always_comb begin
        case (model)
            1:       cmp_in = glitch;
            2:       cmp_in = ~glitch;
            default: cmp_in = (int'(trim) > 37) ^ glitch;
        endcase
    end

    opamp_trim_ctrl #(.TRIM_W(TW), .SETTLE_CYC(SC)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .abort(abort),
        .cmp_in(cmp_in), .man_load(man_load), .man_trim(man_trim),
        .trim(trim), .cal_en(cal_en), .busy(busy), .done(done), .cal_ok(cal_ok)
    );

    typedef struct {
        int   model;
        logic with_man;
        int   man_val;
        logic restart;
        int   glitch_at;
        int   exp_trim;
    } vec_t;

    vec_t vecs [6];
    int   trials [6] = '{32, 48, 40, 36, 38, 37};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic calibrate(input vec_t v);
        bit got;
        model    = v.model;
        man_load = v.with_man;
        man_trim = TW'(v.man_val);
        start    = 1'b1;
        tick();
        start    = 1'b0;
        man_load = 1'b0;
        chk("start_busy", int'(busy), 1);
        chk("start_cal_en", int'(cal_en), 1);
        chk("start_trim_mid", int'(trim), 32);
        got = 1'b0;
        for (int c = 1; c <= LAT + 5 && !got; c++) begin
            if (c == 10 && v.restart) start = 1'b1;
            glitch = (c == v.glitch_at);
            tick();
            start  = 1'b0;
            glitch = 1'b0;
            if (v.model == 0 && (c - 1) % PER == 0 && (c - 1) / PER < 6)
                chk("trial_code", int'(trim), trials[(c - 1) / PER]);
            if (done) begin
                got = 1'b1;
                chk("done_latency", c, LAT);
            end
        end
        if (!got) chk("done_timeout", 0, 1);
        chk("final_trim", int'(trim), v.exp_trim);
        chk("final_cal_ok", int'(cal_ok), 1);
        chk("final_cal_en", int'(cal_en), 0);
        chk("final_busy", int'(busy), 0);
        tick();
        chk("done_one_cycle", int'(done), 0);
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; start = 1'b0; abort = 1'b0;
        man_load = 1'b0; man_trim = '0; model = 0; glitch = 1'b0;

        vecs[0] = '{model: 0, with_man: 1'b0, man_val: 0, restart: 1'b0, glitch_at: 0, exp_trim: 37};
        vecs[1] = '{model: 1, with_man: 1'b0, man_val: 0, restart: 1'b0, glitch_at: 0, exp_trim: 63};
        vecs[2] = '{model: 2, with_man: 1'b0, man_val: 0, restart: 1'b0, glitch_at: 0, exp_trim: 0};
        vecs[3] = '{model: 0, with_man: 1'b1, man_val: 9, restart: 1'b0, glitch_at: 0, exp_trim: 37};
        vecs[4] = '{model: 0, with_man: 1'b0, man_val: 0, restart: 1'b1, glitch_at: 0, exp_trim: 37};
        vecs[5] = '{model: 0, with_man: 1'b0, man_val: 0, restart: 1'b0, glitch_at: 2 * PER + 5, exp_trim: 37};

        tick();
        tick();
        chk("rst_trim", int'(trim), 32);
        chk("rst_cal_en", int'(cal_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_cal_ok", int'(cal_ok), 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) calibrate(vecs[i]);

        // manual load, then abort mid-calibration
        model = 0; man_trim = 6'd5; man_load = 1'b1;
        tick();
        man_load = 1'b0;
        chk("man_load_trim", int'(trim), 5);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_clears_cal_ok", int'(cal_ok), 0);
        for (int c = 1; c < 12; c++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_cal_en", int'(cal_en), 0);
        chk("abort_trim_saved", int'(trim), 5);
        begin
            int seen = 0;
            for (int c = 0; c < LAT + 5; c++) begin
                tick();
                if (done) seen++;
            end
            chk("abort_no_done", seen, 0);
        end
        chk("abort_cal_ok", int'(cal_ok), 0);

        // abort in IDLE leaves trim alone
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("idle_abort_trim", int'(trim), 5);

        // ena low in IDLE blocks start and man_load
        ena = 1'b0; start = 1'b1; man_load = 1'b1; man_trim = 6'd20;
        tick();
        start = 1'b0; man_load = 1'b0;
        chk("ena_low_busy", int'(busy), 0);
        chk("ena_low_trim", int'(trim), 5);
        ena = 1'b1;

        // ena low mid-calibration aborts to saved code
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 7; c++) tick();
        ena = 1'b0;
        tick();
        ena = 1'b1;
        chk("ena_abort_busy", int'(busy), 0);
        chk("ena_abort_trim", int'(trim), 5);

        // reset mid-calibration returns to mid-scale, not the saved code
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 8; c++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_trim", int'(trim), 32);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_cal_en", int'(cal_en), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
